// File: rtl/phase_tick_pkg.sv
// Shared types and constants for the phase-tick timer and its upstream sequence monitor.
package phase_tick_pkg;

  localparam int PHASE_W = 2;
  localparam logic [PHASE_W-1:0] PHASE_LAST = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DONE  = 2'b10,
    ST_ABORT = 2'b11
  } state_e;

  // Expected successor of an upstream phase (wraps 11 -> 00).
  function automatic logic [PHASE_W-1:0] phase_succ(input logic [PHASE_W-1:0] p);
    return p + 2'b01;
  endfunction

endpackage

// File: rtl/phase_seq_monitor.sv
// Tracks the upstream phase/tick history and flags any break in the 00->01->10->11 cadence.
import phase_tick_pkg::*;

module phase_seq_monitor (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               tick_in,
  input  logic               clr,
  output logic               mismatch,
  output logic               seq_err
);

  logic [PHASE_W-1:0] prev_phase_r;
  logic               prev_valid_r;
  logic               seq_err_r;
  logic               mismatch_s;

  // The first cycle after reset has no history, so it is never judged.
  always_comb begin
    mismatch_s = 1'b0;
    if (prev_valid_r) begin
      mismatch_s = (phase_in != phase_succ(prev_phase_r)) ||
                   (tick_in != (prev_phase_r == PHASE_LAST));
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // History registers and sticky error; an accepted start wins over a same-cycle mismatch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_phase_r <= 2'b00;
      prev_valid_r <= 1'b0;
      seq_err_r    <= 1'b0;
    end else begin
      prev_phase_r <= phase_in;
      prev_valid_r <= 1'b1;
      if (clr) begin
        seq_err_r <= 1'b0;
      end else if (mismatch_s) begin
        seq_err_r <= 1'b1;
      end
    end
  end

  assign mismatch = mismatch_s;
  assign seq_err  = seq_err_r;

endmodule

// File: rtl/phase_tick_timer.sv
// Counts upstream ticks up to a latched target; aborts the run if the upstream cadence breaks.
import phase_tick_pkg::*;

module phase_tick_timer #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               tick_in,
  input  logic               start,
  input  logic [CNT_W-1:0]   target,
  input  logic               ack,
  output logic               busy,
  output logic               done,
  output logic               abort,
  output logic [CNT_W-1:0]   count,
  output logic               seq_err
);

  state_e             state_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   target_r;
  logic               busy_r;
  logic               done_r;
  logic               abort_r;
  logic               mismatch_s;
  logic               clr_s;
  logic [CNT_W-1:0]   count_inc_s;
  logic               terminal_s;

  assign clr_s       = (state_r == ST_IDLE) && start;
  assign count_inc_s = count_r + CNT_W'(1);
  assign terminal_s  = (count_inc_s == target_r);

  phase_seq_monitor u_mon (
    .clk      (clk),
    .reset_n  (reset_n),
    .phase_in (phase_in),
    .tick_in  (tick_in),
    .clr      (clr_s),
    .mismatch (mismatch_s),
    .seq_err  (seq_err)
  );

  // Run-control FSM; status flags are registered alongside each state transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      count_r  <= {CNT_W{1'b0}};
      target_r <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      abort_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            count_r <= {CNT_W{1'b0}};
            if (target != {CNT_W{1'b0}}) begin
              target_r <= target;
              state_r  <= ST_RUN;
              busy_r   <= 1'b1;
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Abort beats a coincident terminal tick and leaves the count untouched.
          if (mismatch_s) begin
            state_r <= ST_ABORT;
            busy_r  <= 1'b0;
            abort_r <= 1'b1;
          end else if (tick_in) begin
            count_r <= count_inc_s;
            if (terminal_s) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        ST_DONE, ST_ABORT: begin
          if (ack) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
            abort_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          abort_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign abort = abort_r;
  assign count = count_r;

endmodule

// File: tb/tb_phase_tick_timer.sv
// Self-checking bench: an 8-bit and a 2-bit timer share one upstream phase stream, checked against a rule-level model.
module tb_phase_tick_timer;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DONE  = 2;
  localparam int M_ABORT = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] phase_in;
  logic       tick_in;

  logic       start_a, ack_a, busy_a, done_a, abort_a, seq_err_a;
  logic [7:0] target_a, count_a;
  logic       start_b, ack_b, busy_b, done_b, abort_b, seq_err_b;
  logic [1:0] target_b, count_b;

  int checks = 0;
  int errors = 0;

  int m_st[2];
  int m_cnt[2];
  int m_tgt[2];
  bit m_se[2];
  int m_pp;
  bit m_pv;

  phase_tick_timer #(.CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .phase_in(phase_in), .tick_in(tick_in),
    .start(start_a), .target(target_a), .ack(ack_a),
    .busy(busy_a), .done(done_a), .abort(abort_a), .count(count_a), .seq_err(seq_err_a)
  );

  phase_tick_timer #(.CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .phase_in(phase_in), .tick_in(tick_in),
    .start(start_b), .target(target_b), .ack(ack_b),
    .busy(busy_b), .done(done_b), .abort(abort_b), .count(count_b), .seq_err(seq_err_b)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE; m_cnt[i] = 0; m_tgt[i] = 0; m_se[i] = 1'b0;
    end
    m_pp = 0; m_pv = 1'b0;
  endtask

  // One clock edge of the timer rules applied to both instances.
  task automatic model_edge();
    bit mm;
    bit st_i [2];
    bit ak_i [2];
    int tg_i [2];
    st_i[0] = start_a; ak_i[0] = ack_a; tg_i[0] = int'(target_a);
    st_i[1] = start_b; ak_i[1] = ack_b; tg_i[1] = int'(target_b);
    mm = m_pv && ((int'(phase_in) != (m_pp + 1) % 4) || (tick_in != (m_pp == 3)));
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] == M_IDLE && st_i[i]) m_se[i] = 1'b0;
      else if (mm) m_se[i] = 1'b1;
      case (m_st[i])
        M_IDLE: if (st_i[i]) begin
          m_cnt[i] = 0;
          if (tg_i[i] != 0) begin m_tgt[i] = tg_i[i]; m_st[i] = M_RUN; end
          else m_st[i] = M_DONE;
        end
        M_RUN: if (mm) m_st[i] = M_ABORT;
               else if (tick_in) begin
                 m_cnt[i] = m_cnt[i] + 1;
                 if (m_cnt[i] == m_tgt[i]) m_st[i] = M_DONE;
               end
        default: if (ak_i[i]) m_st[i] = M_IDLE;
      endcase
    end
    m_pp = int'(phase_in); m_pv = 1'b1;
  endtask

  function automatic logic [11:0] exp_a();
    return {m_st[0] == M_RUN, m_st[0] == M_DONE, m_st[0] == M_ABORT, m_se[0], 8'(m_cnt[0])};
  endfunction

  function automatic logic [5:0] exp_b();
    return {m_st[1] == M_RUN, m_st[1] == M_DONE, m_st[1] == M_ABORT, m_se[1], 2'(m_cnt[1])};
  endfunction

  // Advance one clock, then present the next clean upstream phase.
  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    phase_in = phase_in + 2'd1;
    tick_in  = (phase_in == 2'd0);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy_a, done_a, abort_a, seq_err_a, count_a} !== 12'd0) begin
      errors++; $display("FAIL reset_a got %h exp 000", {busy_a, done_a, abort_a, seq_err_a, count_a});
    end
    checks++;
    if ({busy_b, done_b, abort_b, seq_err_b, count_b} !== 6'd0) begin
      errors++; $display("FAIL reset_b got %h exp 00", {busy_b, done_b, abort_b, seq_err_b, count_b});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_clean_run();
    int n = 0;
    bit last_tick = 1'b0;
    start_a = 1'b1; target_a = 8'd3;
    step();
    start_a = 1'b0;
    checks++;
    if ({busy_a, count_a} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL clean_busy got %b/%0d exp 1/0", busy_a, count_a);
    end
    while (!done_a && n < 40) begin
      last_tick = tick_in;
      step(); n++;
      checks++;
      if ({busy_a, done_a, abort_a, seq_err_a, count_a} !== exp_a()) begin
        errors++; $display("FAIL clean_cycle got %h exp %h", {busy_a, done_a, abort_a, seq_err_a, count_a}, exp_a());
      end
    end
    checks++;
    if ({done_a, count_a, last_tick} !== {1'b1, 8'd3, 1'b1}) begin
      errors++; $display("FAIL clean_done got done=%b cnt=%0d tick=%b exp 1/3/1", done_a, count_a, last_tick);
    end
    ack_a = 1'b1; step(); ack_a = 1'b0;
    checks++;
    if ({busy_a, done_a, abort_a, count_a} !== {3'b000, 8'd3}) begin
      errors++; $display("FAIL clean_ack got %h exp 003", {busy_a, done_a, abort_a, count_a});
    end
  endtask

  task automatic test_zero_target();
    start_a = 1'b1; target_a = 8'd0;
    step();
    start_a = 1'b0;
    checks++;
    if ({busy_a, done_a, abort_a, count_a} !== {3'b010, 8'd0}) begin
      errors++; $display("FAIL zero_done got %h exp 200", {busy_a, done_a, abort_a, count_a});
    end
    ack_a = 1'b1; step(); ack_a = 1'b0;
    checks++;
    if ({busy_a, done_a} !== 2'b00) begin
      errors++; $display("FAIL zero_ack got %b exp 00", {busy_a, done_a});
    end
  endtask

  task automatic test_abort();
    int n = 0;
    start_a = 1'b1; target_a = 8'd5;
    step();
    start_a = 1'b0;
    while (!(m_cnt[0] == 1 && m_pp == 1) && n < 40) begin step(); n++; end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL abort_setup timeout got %0d exp <40", n); end
    phase_in = 2'b11; tick_in = 1'b0;
    step();
    checks++;
    if ({abort_a, busy_a, seq_err_a, count_a} !== {3'b101, 8'd1}) begin
      errors++; $display("FAIL abort_hit got a=%b b=%b se=%b cnt=%0d exp 1/0/1/1", abort_a, busy_a, seq_err_a, count_a);
    end
    ack_a = 1'b1; step(); ack_a = 1'b0;
    checks++;
    if ({abort_a, busy_a, seq_err_a, count_a} !== {3'b001, 8'd1}) begin
      errors++; $display("FAIL abort_ack got a=%b b=%b se=%b cnt=%0d exp 0/0/1/1", abort_a, busy_a, seq_err_a, count_a);
    end
    start_a = 1'b1; target_a = 8'd2;
    step();
    start_a = 1'b0;
    checks++;
    if ({busy_a, seq_err_a, count_a} !== {2'b10, 8'd0}) begin
      errors++; $display("FAIL abort_restart got b=%b se=%b cnt=%0d exp 1/0/0", busy_a, seq_err_a, count_a);
    end
    n = 0;
    while (!done_a && n < 40) begin step(); n++; end
    ack_a = 1'b1; step(); ack_a = 1'b0;
  endtask

  task automatic test_spurious();
    int n = 0;
    while (phase_in != 2'd2 && n < 8) begin step(); n++; end
    tick_in = 1'b1;
    step();
    checks++;
    if ({busy_a, done_a, abort_a, seq_err_a} !== 4'b0001) begin
      errors++; $display("FAIL spurious got %b exp 0001", {busy_a, done_a, abort_a, seq_err_a});
    end
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    start_a = 1'b1; target_a = 8'd9;
    step();
    start_a = 1'b0;
    while (m_cnt[0] != 2 && n < 40) begin step(); n++; end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({busy_a, done_a, abort_a, seq_err_a, count_a} !== 12'd0) begin
      errors++; $display("FAIL rst_mid got %h exp 000", {busy_a, done_a, abort_a, seq_err_a, count_a});
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    phase_in = 2'd2; tick_in = 1'b0;
    step();
    checks++;
    if ({busy_a, seq_err_a, seq_err_b} !== 3'b000) begin
      errors++; $display("FAIL rst_first got %b exp 000", {busy_a, seq_err_a, seq_err_b});
    end
    step();
    checks++;
    if (seq_err_a !== 1'b0) begin
      errors++; $display("FAIL rst_second got %b exp 0", seq_err_a);
    end
  endtask

  task automatic test_narrow();
    int n = 0;
    start_b = 1'b1; target_b = 2'd3;
    step();
    start_b = 1'b0;
    while (!done_b && n < 40) begin step(); n++; end
    checks++;
    if ({done_b, count_b} !== {1'b1, 2'd3}) begin
      errors++; $display("FAIL narrow_done got d=%b cnt=%0d exp 1/3", done_b, count_b);
    end
    start_b = 1'b1; ack_b = 1'b1; target_b = 2'd2;
    step();
    start_b = 1'b0; ack_b = 1'b0;
    checks++;
    if ({busy_b, done_b, count_b} !== {2'b00, 2'd3}) begin
      errors++; $display("FAIL narrow_ack got b=%b d=%b cnt=%0d exp 0/0/3", busy_b, done_b, count_b);
    end
    step();
    checks++;
    if ({busy_b, done_b, count_b} !== {2'b00, 2'd3}) begin
      errors++; $display("FAIL narrow_idle got b=%b d=%b cnt=%0d exp 0/0/3", busy_b, done_b, count_b);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      start_a  = ($urandom_range(0, 4) == 0);
      ack_a    = ($urandom_range(0, 2) == 0);
      target_a = 8'($urandom_range(0, 6));
      start_b  = ($urandom_range(0, 4) == 0);
      ack_b    = ($urandom_range(0, 2) == 0);
      target_b = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        phase_in = 2'($urandom_range(0, 3));
        tick_in  = 1'($urandom_range(0, 1));
      end
      step();
      checks++;
      if ({busy_a, done_a, abort_a, seq_err_a, count_a} !== exp_a()) begin
        errors++; $display("FAIL rand_a cyc %0d got %h exp %h", c, {busy_a, done_a, abort_a, seq_err_a, count_a}, exp_a());
      end
      checks++;
      if ({busy_b, done_b, abort_b, seq_err_b, count_b} !== exp_b()) begin
        errors++; $display("FAIL rand_b cyc %0d got %h exp %h", c, {busy_b, done_b, abort_b, seq_err_b, count_b}, exp_b());
      end
    end
    start_a = 1'b0; ack_a = 1'b0; start_b = 1'b0; ack_b = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    phase_in = 2'd0; tick_in = 1'b0;
    start_a = 1'b0; ack_a = 1'b0; target_a = 8'd0;
    start_b = 1'b0; ack_b = 1'b0; target_b = 2'd0;
    model_reset();
    test_reset();
    test_clean_run();
    test_zero_target();
    test_abort();
    test_spurious();
    test_reset_mid_run();
    test_narrow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
